mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 189 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit (radix-2^DIGIT_BITS multiply, restoring divide)
module mul_div_unit #(
    parameter int WIDTH      = 32,  // even, >= 4
    parameter int DIGIT_BITS = 4    // must divide WIDTH
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] High,
    output logic [WIDTH-1:0] Low,
    output logic             DivByZero
);

    localparam int W     = WIDTH;
    localparam int D     = DIGIT_BITS;
    localparam int N     = W / D;
    localparam int CNT_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t           state_q, state_d;
    // Multiply: {partial product high, remaining multiplier digits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*W-1:0]   acc_q, acc_d;
    // |A| for multiply, |B| for divide; the operand added/subtracted each step.
    logic [W-1:0]     opnd_q, opnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;          // product / quotient sign
    logic             neg_rem_q, neg_rem_d;  // remainder follows the dividend sign
    logic             zero_q, zero_d;        // divide with B == 0
    logic             is_div_q, is_div_d;
    logic [W-1:0]     high_q, high_d;
    logic [W-1:0]     low_q, low_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic             a_neg, b_neg;
    logic [W-1:0]     a_abs, b_abs;
    logic [D-1:0]     digit;
    logic [W+D-1:0]   partial;
    logic [2*W-1:0]   mul_next;
    logic [W:0]       trial;
    logic [2*W-1:0]   div_next;
    logic [2*W-1:0]   prod;

    // Operand magnitudes and one iteration step of each datapath
    always_comb begin
        a_neg    = Op[0] & A[W-1];
        b_neg    = Op[0] & B[W-1];
        a_abs    = a_neg ? -A : A;
        b_abs    = b_neg ? -B : B;
        digit    = acc_q[D-1:0];
        partial  = {{D{1'b0}}, acc_q[2*W-1:W]}
                 + ({{D{1'b0}}, opnd_q} * {{W{1'b0}}, digit});
        mul_next = {partial, acc_q[W-1:D]};
        trial    = {acc_q[2*W-1:W], acc_q[W-1]} - {1'b0, opnd_q};
        if (!trial[W]) begin
            div_next = {trial[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
            div_next = {acc_q[2*W-2:0], 1'b0};
        end
        prod = neg_q ? -acc_q : acc_q;
    end

    // Controller next state and register updates
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        is_div_d  = is_div_q;
        high_d    = high_q;
        low_d     = low_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    cnt_d     = '0;
                    is_div_d  = Op[1];
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (Op[1]) begin
                        opnd_d = b_abs;
                        zero_d = (B == '0);
                        if (B == '0) begin
                            // raw A is kept so FIX can return it as the remainder
                            acc_d   = {{W{1'b0}}, A};
                            state_d = S_FIX;
                        end else begin
                            acc_d   = {{W{1'b0}}, a_abs};
                            state_d = S_DIV;
                        end
                    end else begin
                        opnd_d  = a_abs;
                        zero_d  = 1'b0;
                        acc_d   = {{W{1'b0}}, b_abs};
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == MUL_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == DIV_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (zero_q) begin
                    high_d = acc_q[W-1:0];
                    low_d  = '1;
                    dbz_d  = 1'b1;
                end else if (is_div_q) begin
                    // most-negative / -1 wraps back to most-negative here
                    low_d  = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
                    high_d = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
                    dbz_d  = 1'b0;
                end else begin
                    {high_d, low_d} = prod;
                    dbz_d  = 1'b0;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers, cleared immediately by reset
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            is_div_q  <= 1'b0;
            high_q    <= '0;
            low_q     <= '0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            is_div_q  <= is_div_d;
            high_q    <= high_d;
            low_q     <= low_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
        end
    end

    assign Busy      = (state_q != S_IDLE);
    assign Done      = done_q;
    assign High      = high_q;
    assign Low       = low_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

    logic        CLK;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [31:0] High;
    logic [31:0] Low;
    logic        DivByZero;

    int total = 0;
    int bad   = 0;

    mul_div_unit #(.WIDTH(32), .DIGIT_BITS(4)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .High      (High),
        .Low       (Low),
        .DivByZero (DivByZero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive a request, then return #1 after the accepting edge k
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        A     = 32'hDEAD_BEEF;
        B     = 32'h0BAD_F00D;
    endtask

    // wait for Done, counting edges from the current point, checking Busy on the way
    task automatic wait_done(input int exp_edges, input string tag);
        int n;
        bit busy_ok;
        n       = 0;
        busy_ok = 1'b1;
        while (Done !== 1'b1 && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
            if (Done !== 1'b1 && Busy !== 1'b1) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, n, exp_edges);
        check({tag, "_busy_during"}, busy_ok, 1);
        check({tag, "_busy_at_done"}, Busy, 0);
    endtask

    initial begin
        int done_seen;
        Reset = 1'b0;
        Start = 1'b0;
        Op    = 2'b00;
        A     = '0;
        B     = '0;

        // reset state
        @(posedge CLK);
        #1;
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_high", High, 0);
        check("rst_low",  Low, 0);
        check("rst_dbz",  DivByZero, 0);
        @(negedge CLK);
        Reset = 1'b1;
        @(posedge CLK);
        #1;

        // MULTU
        start_op(2'b00, 32'h0000_054A, 32'h0000_15ED);
        check("multu_busy_k", Busy, 1);
        wait_done(9, "multu");
        check("multu_high", High, 32'h0000_0000);
        check("multu_low",  Low,  32'h0073_F782);
        @(posedge CLK);
        #1;
        check("multu_done_one_cycle", Done, 0);
        check("multu_hold_low", Low, 32'h0073_F782);

        // MULT -1 * 2
        start_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_done(9, "mult");
        check("mult_high", High, 32'hFFFF_FFFF);
        check("mult_low",  Low,  32'hFFFF_FFFE);
        check("mult_dbz",  DivByZero, 0);

        // MULT -3 * -5
        start_op(2'b01, 32'hFFFF_FFFD, 32'hFFFF_FFFB);
        wait_done(9, "mult_nn");
        check("mult_nn_high", High, 32'h0000_0000);
        check("mult_nn_low",  Low,  32'h0000_000F);

        // DIV -7 / 2
        start_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(33, "div");
        check("div_low",  Low,  32'hFFFF_FFFD);
        check("div_high", High, 32'hFFFF_FFFF);

        // DIVU 100 / 7
        start_op(2'b10, 32'd100, 32'd7);
        wait_done(33, "divu");
        check("divu_low",  Low,  32'd14);
        check("divu_high", High, 32'd2);

        // DIVU by zero
        start_op(2'b10, 32'h1234_5678, 32'h0000_0000);
        wait_done(1, "divz");
        check("divz_dbz",  DivByZero, 1);
        check("divz_low",  Low,  32'hFFFF_FFFF);
        check("divz_high", High, 32'h1234_5678);

        // DIV most-negative / -1
        start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(33, "divmn");
        check("divmn_low",  Low,  32'h8000_0000);
        check("divmn_high", High, 32'h0000_0000);
        check("divmn_dbz",  DivByZero, 0);

        // second Start at k+3 ignored, then Start in Done cycle accepted
        start_op(2'b00, 32'd3, 32'd5);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        Start = 1'b1;
        Op    = 2'b10;
        A     = 32'd7;
        B     = 32'd9;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        wait_done(6, "ign");
        check("ign_low",  Low,  32'd15);
        check("ign_high", High, 32'd0);
        start_op(2'b00, 32'd2, 32'd3);
        check("b2b_busy", Busy, 1);
        check("b2b_hold_low", Low, 32'd15);
        wait_done(9, "b2b");
        check("b2b_low", Low, 32'd6);

        // reset mid-MULT
        start_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #2;
        Reset = 1'b0;
        #1;
        check("arst_busy", Busy, 0);
        check("arst_done", Done, 0);
        check("arst_high", High, 0);
        check("arst_low",  Low, 0);
        check("arst_dbz",  DivByZero, 0);
        @(negedge CLK);
        Reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            if (Done === 1'b1) done_seen++;
        end
        check("arst_no_done", done_seen, 0);
        check("arst_idle", Busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
